// File: rtl/ctrl_pipe_reg.sv
// ID/EX control-path pipeline register with multi-cycle bubble insertion,
// hold, flush and a saturating bubble counter.
module ctrl_pipe_reg #(
  parameter int JUMP_W   = 2,
  parameter int ALU_OP_W = 4,
  parameter int LEN_W    = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_stall,
  input  logic [LEN_W-1:0]    stall_len,
  input  logic                hold,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [JUMP_W-1:0]   jump,
  input  logic                branch,
  input  logic                mem_read,
  input  logic                mem_to_reg,
  input  logic                mem_write,
  input  logic                alu_src,
  input  logic                reg_write,
  input  logic                reg_dst,
  input  logic [ALU_OP_W-1:0] alu_op,
  output logic [JUMP_W-1:0]   jump_out,
  output logic                branch_out,
  output logic                mem_read_out,
  output logic                mem_to_reg_out,
  output logic                mem_write_out,
  output logic                alu_src_out,
  output logic                reg_write_out,
  output logic                reg_dst_out,
  output logic [ALU_OP_W-1:0] alu_op_out,
  output logic                out_valid,
  output logic                id_stall,
  output logic [CNT_W-1:0]    bubble_count
);

  localparam int CTL_W = JUMP_W + 7 + ALU_OP_W;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  logic [0:0]       state;
  logic [LEN_W-1:0] rem;
  logic [CTL_W-1:0] ctl_d;
  logic [CTL_W-1:0] ctl_q;

  assign ctl_d = {jump, branch, mem_read, mem_to_reg, mem_write,
                  alu_src, reg_write, reg_dst, alu_op};

  assign {jump_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out,
          alu_src_out, reg_write_out, reg_dst_out, alu_op_out} = ctl_q;

  // Stays high through hold so the upstream stage sees exactly L bubble edges.
  assign id_stall = rst & ~flush & ((state == BUBBLE) | ex_stall);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q        <= '0;
      out_valid    <= 1'b0;
      bubble_count <= '0;
      rem          <= '0;
      state        <= IDLE;
    end else if (flush) begin
      ctl_q     <= '0;
      out_valid <= 1'b0;
      rem       <= '0;
      state     <= IDLE;
    end else if (hold) begin
      // frozen
    end else if (state == BUBBLE) begin
      ctl_q     <= '0;
      out_valid <= 1'b0;
      if (bubble_count != '1) bubble_count <= bubble_count + 1'b1;
      rem <= rem - 1'b1;
      if (rem == LEN_W'(1)) state <= IDLE;
    end else if (ex_stall) begin
      ctl_q     <= '0;
      out_valid <= 1'b0;
      if (bubble_count != '1) bubble_count <= bubble_count + 1'b1;
      if (stall_len > LEN_W'(1)) begin
        rem   <= stall_len - 1'b1;
        state <= BUBBLE;
      end
    end else begin
      ctl_q     <= in_valid ? ctl_d : '0;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Self-checking bench for ctrl_pipe_reg: a default instance and a CNT_W=2
// instance share stimulus and are checked against a bubble-budget model.
module tb_ctrl_pipe_reg;

  typedef struct packed {
    logic [1:0] jump;
    logic       branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst;
    logic [3:0] alu_op;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, ex_stall = 1'b0, hold = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [2:0] stall_len = '0;
  ctl_t       ctl = '0;

  logic [1:0] a_jump, b_jump;
  logic       a_br, a_mr, a_m2r, a_mw, a_as, a_rw, a_rd, a_valid, a_stall;
  logic       b_br, b_mr, b_m2r, b_mw, b_as, b_rw, b_rd, b_valid, b_stall;
  logic [3:0] a_op, b_op;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  ctl_t       a_q, b_q;

  assign a_q = {a_jump, a_br, a_mr, a_m2r, a_mw, a_as, a_rw, a_rd, a_op};
  assign b_q = {b_jump, b_br, b_mr, b_m2r, b_mw, b_as, b_rw, b_rd, b_op};

  ctrl_pipe_reg dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .stall_len(stall_len), .hold(hold),
    .flush(flush), .in_valid(in_valid), .jump(ctl.jump), .branch(ctl.branch),
    .mem_read(ctl.mem_read), .mem_to_reg(ctl.mem_to_reg), .mem_write(ctl.mem_write),
    .alu_src(ctl.alu_src), .reg_write(ctl.reg_write), .reg_dst(ctl.reg_dst),
    .alu_op(ctl.alu_op), .jump_out(a_jump), .branch_out(a_br), .mem_read_out(a_mr),
    .mem_to_reg_out(a_m2r), .mem_write_out(a_mw), .alu_src_out(a_as),
    .reg_write_out(a_rw), .reg_dst_out(a_rd), .alu_op_out(a_op),
    .out_valid(a_valid), .id_stall(a_stall), .bubble_count(a_cnt)
  );

  ctrl_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .stall_len(stall_len), .hold(hold),
    .flush(flush), .in_valid(in_valid), .jump(ctl.jump), .branch(ctl.branch),
    .mem_read(ctl.mem_read), .mem_to_reg(ctl.mem_to_reg), .mem_write(ctl.mem_write),
    .alu_src(ctl.alu_src), .reg_write(ctl.reg_write), .reg_dst(ctl.reg_dst),
    .alu_op(ctl.alu_op), .jump_out(b_jump), .branch_out(b_br), .mem_read_out(b_mr),
    .mem_to_reg_out(b_m2r), .mem_write_out(b_mw), .alu_src_out(b_as),
    .reg_write_out(b_rw), .reg_dst_out(b_rd), .alu_op_out(b_op),
    .out_valid(b_valid), .id_stall(b_stall), .bubble_count(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: pending = bubble edges still owed; raw = total bubbles ever inserted since reset.
  ctl_t m_ctl = '0;
  logic m_valid = 1'b0;
  int   pending = 0;
  int   raw = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_ctl = '0; m_valid = 1'b0; pending = 0; raw = 0;
    end else if (flush) begin
      m_ctl = '0; m_valid = 1'b0; pending = 0;
    end else if (hold) begin
    end else if (pending > 0) begin
      m_ctl = '0; m_valid = 1'b0; raw++; pending--;
    end else if (ex_stall) begin
      m_ctl = '0; m_valid = 1'b0; raw++;
      pending = ((stall_len == 3'd0) ? 1 : int'(stall_len)) - 1;
    end else begin
      m_valid = in_valid;
      m_ctl   = in_valid ? ctl : '0;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Inputs change at negedge; outputs and id_stall are compared 2 time units later.
  always @(negedge clk) begin
    logic exp_stall;
    #2;
    exp_stall = rst && !flush && (pending > 0 || ex_stall);
    chk("ctl",       32'(a_q),     32'(m_ctl));
    chk("valid",     32'(a_valid), 32'(m_valid));
    chk("id_stall",  32'(a_stall), 32'(exp_stall));
    chk("count",     32'(a_cnt),   32'(sat(raw, 255)));
    chk("ctl_s",     32'(b_q),     32'(m_ctl));
    chk("valid_s",   32'(b_valid), 32'(m_valid));
    chk("id_stall_s",32'(b_stall), 32'(exp_stall));
    chk("count_s",   32'(b_cnt),   32'(sat(raw, 3)));
  end

  task automatic step(input logic r, input logic st, input logic [2:0] len,
                      input logic h, input logic f, input logic v, input ctl_t c);
    @(negedge clk);
    rst = r; ex_stall = st; stall_len = len; hold = h; flush = f; in_valid = v; ctl = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  ctl_t c_a, c_b, c_c, c_rd;

  initial begin
    c_a = '0; c_a.alu_op = 4'h2; c_a.reg_write = 1'b1;
    c_b = '0; c_b.mem_read = 1'b1;
    c_c = {2'b10, 7'b1010110, 4'h9};

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      c_rd = ctl_t'($urandom);
      step(1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1, c_rd);
      #1 chk("lit_rst_stall", 32'(a_stall), 32'd0);
    end
    after_edge();
    chk("lit_rst_valid", 32'(a_valid), 32'd0);
    chk("lit_rst_cnt", 32'(a_cnt), 32'd0);

    // Release and load
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_a);
    after_edge();
    chk("lit_load_op", 32'(a_op), 32'h2);
    chk("lit_load_rw", 32'(a_rw), 32'd1);
    chk("lit_load_valid", 32'(a_valid), 32'd1);

    // Single bubble, stall_len 0 treated as 1
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, c_b);
    #1 chk("lit_single_stall", 32'(a_stall), 32'd1);
    after_edge();
    chk("lit_single_valid", 32'(a_valid), 32'd0);
    chk("lit_single_mr", 32'(a_mr), 32'd0);
    chk("lit_single_cnt", 32'(a_cnt), 32'd1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_b);
    #1 chk("lit_single_stall_off", 32'(a_stall), 32'd0);
    after_edge();
    chk("lit_single_reload", 32'(a_mr), 32'd1);

    // Three-cycle bubble
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, c_c);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_c);
      #1 chk("lit_multi_stall", 32'(a_stall), 32'd1);
    end
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_c);
    #1 chk("lit_multi_stall_off", 32'(a_stall), 32'd0);
    chk("lit_multi_cnt", 32'(a_cnt), 32'd4);
    after_edge();
    chk("lit_multi_load", 32'(a_q), 32'(c_c));

    // Hold inside bubble; ex_stall re-request in BUBBLE is ignored
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, c_a);
    step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, c_a);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, c_a);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, c_a);
    #1 chk("lit_hold_stall", 32'(a_stall), 32'd1);
    chk("lit_hold_cnt", 32'(a_cnt), 32'd6);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_a);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_a);
    after_edge();
    chk("lit_hold_cnt_end", 32'(a_cnt), 32'd7);
    chk("lit_hold_load", 32'(a_valid), 32'd1);

    // Flush in BUBBLE with rem=2
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, c_b);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, c_b);
    #1 chk("lit_flush_stall", 32'(a_stall), 32'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_c);
    #1 chk("lit_flush_idle", 32'(a_stall), 32'd0);
    chk("lit_flush_cnt", 32'(a_cnt), 32'd8);
    // Flush beats hold in IDLE
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, c_a);
    after_edge();
    chk("lit_flush_hold", 32'(a_valid), 32'd0);
    // Hold in IDLE keeps a loaded bundle; invalid input loads a bubble
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_c);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, c_a);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, c_b);
    after_edge();
    chk("lit_idle_hold", 32'(a_q), 32'(c_c));
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, c_c);
    after_edge();
    chk("lit_invalid", 32'(a_q), 32'd0);

    // Reset mid-bubble
    step(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, c_a);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_a);
    after_edge();
    chk("lit_rst_mid_cnt", 32'(a_cnt), 32'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_a);
    #1 chk("lit_rst_mid_idle", 32'(a_stall), 32'd0);

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, c_b);
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, c_b);
    end
    after_edge();
    chk("lit_sat_small", 32'(b_cnt), 32'd3);
    chk("lit_sat_big", 32'(a_cnt), 32'd5);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, c_b);
    @(negedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
